vga_line_fetcher: RTL
=====================

VGA_LINE_FETCHER -- requirements
Module: vga_line_fetcher

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: pixels (16-bit words) per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: lines per frame.
REQ-003 SHALL have parameter LINE_STRIDE, default 1024: word-address distance between lines.
REQ-004 SHALL have parameter BASE_ADDR, default 24'h000000: word address of pixel (0,0).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: pixel FIFO entries (power of two).
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 frame_start  input  1  one-cycle pulse; begins fetch of a new frame.
REQ-009 mem_addr  output  24  word address presented to the memory controller.
REQ-010 mem_request  output  1  read request, held until mem_data_ready.
REQ-011 mem_n_write_enable  output  1  constant 1 (read).
REQ-012 mem_data_read_size  output  9  constant 9'd1 (single-word read).
REQ-013 mem_data_in  input  16  read word (controller data_read[15:0]).
REQ-014 mem_data_ready  input  1  read word valid this cycle.
REQ-015 mem_busy  input  1  controller busy or uninitialised.
REQ-016 pixel_req  input  1  consumer pops one pixel this cycle.
REQ-017 pixel_data  output  16  FIFO head; 16'h0000 when empty.
REQ-018 pixel_valid  output  1  FIFO not empty.
REQ-019 underflow  output  1  sticky: pixel_req seen while empty.
REQ-020 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT, DRAIN, DONE.
REQ-022 IDLE: mem_request=0; frame_start -> x=0, y=0, FIFO flushed, underflow cleared, go to ISSUE.
REQ-023 ISSUE: when fifo_level < FIFO_DEPTH and mem_busy=0, assert mem_request next cycle with mem_addr = (BASE_ADDR + y*LINE_STRIDE + x) mod 2^24; go to WAIT.
REQ-024 WAIT: mem_request and mem_addr held stable; on mem_data_ready, capture mem_data_in into FIFO same edge, deassert mem_request, advance x.
REQ-025 Advance: x==H_ACTIVE-1 -> x=0, y=y+1; else x=x+1; if x==H_ACTIVE-1 and y==V_ACTIVE-1 -> DONE, else -> ISSUE.
REQ-026 At most one request outstanding; no new request issued while FIFO full (level==FIFO_DEPTH).
REQ-027 DONE: mem_request=0; FIFO continues to drain; frame_start -> same actions as REQ-022.
REQ-028 frame_start in ISSUE: restart per REQ-022 immediately.
REQ-029 frame_start in WAIT: deassert mem_request, flush FIFO, clear underflow, go to DRAIN; any mem_data_ready in DRAIN is discarded.
REQ-030 DRAIN: stay until mem_busy=0, then x=0, y=0, go to ISSUE.
REQ-031 Pop: pixel_req with pixel_valid=1 removes head on posedge; pixel_data is combinational head.
REQ-032 Push and pop in same cycle: level unchanged, order preserved, no overflow even when full.
REQ-033 pixel_req with FIFO empty: no pointer change, underflow set to 1 until reset or frame_start.
REQ-034 FIFO pointers wrap modulo FIFO_DEPTH; fifo_level range 0..FIFO_DEPTH.
REQ-035 frame_start coincident with push or pop: flush takes priority; level becomes 0.

Reset
REQ-036 reset=1 on posedge: state IDLE, mem_request=0, mem_addr=0, x=y=0, FIFO empty, fifo_level=0, pixel_valid=0, pixel_data=0, underflow=0.
REQ-037 reset overrides frame_start and mem_data_ready in the same cycle; reset mid-WAIT drops mem_request without waiting for mem_busy.
REQ-038 mem_n_write_enable=1 and mem_data_read_size=9'd1 at all times including reset.

Verification
REQ-039 Reset, frame_start, controller model returns addr[15:0] after 3 cycles, no pops -> requests to addr 0..15, then stall with fifo_level=16, mem_request=0.
REQ-040 H_ACTIVE=4, V_ACTIVE=2, LINE_STRIDE=1024, continuous pop -> addresses 0,1,2,3,1024,1025,1026,1027 in order, then DONE, no further requests.
REQ-041 FIFO full, pixel_req and mem_data_ready same cycle -> fifo_level stays 16, popped/pushed data order intact.
REQ-042 Empty FIFO, pixel_req=1 -> underflow=1, pixel_data=0, level 0; next frame_start -> underflow=0.
REQ-043 frame_start during WAIT with mem_busy held 5 cycles -> mem_request=0 next cycle, late mem_data_ready ignored, first new request at addr BASE_ADDR after mem_busy falls.
REQ-044 reset asserted mid-WAIT -> next cycle all outputs per REQ-036.

Source files
------------

// File: rtl/vga_line_fetcher_if.sv
// Memory-controller read port used by the VGA line fetcher.
// The fetcher drives address/request through the master modport; the
// controller (or a bench model of it) answers through the slave modport.
interface vga_line_fetcher_if;
  logic [23:0] mem_addr;
  logic        mem_request;
  logic        mem_n_write_enable;
  logic [8:0]  mem_data_read_size;
  logic [15:0] mem_data_in;
  logic        mem_data_ready;
  logic        mem_busy;

  modport master (
    output mem_addr, mem_request, mem_n_write_enable, mem_data_read_size,
    input  mem_data_in, mem_data_ready, mem_busy
  );

  modport slave (
    input  mem_addr, mem_request, mem_n_write_enable, mem_data_read_size,
    output mem_data_in, mem_data_ready, mem_busy
  );
endinterface

// File: rtl/vga_line_fetcher.sv
// VGA line fetcher: walks a frame buffer one 16-bit word at a time, keeping
// at most one single-word read outstanding, and queues returned pixels in a
// small FIFO for the scan-out logic. A frame_start that lands while a read is
// in flight parks the fetcher in DRAIN so the stale word is dropped.
module vga_line_fetcher #(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          LINE_STRIDE = 1024,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  vga_line_fetcher_if.master            mem,
  input  logic                          pixel_req,
  output logic [15:0]                   pixel_data,
  output logic                          pixel_valid,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   X_LAST     = 16'(H_ACTIVE - 1);
  localparam logic [15:0]   Y_LAST     = 16'(V_ACTIVE - 1);
  localparam logic [23:0]   STRIDE     = 24'(LINE_STRIDE);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   x_reg, x_next;
  logic [15:0]   y_reg, y_next;
  logic [23:0]   addr_reg, addr_next;
  logic          req_reg, req_next;
  logic          push;
  logic          flush;
  logic          pop;
  logic [23:0]   fetch_addr;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          underflow_reg;

  // Word address of the current (x, y); 24-bit arithmetic wraps naturally.
  assign fetch_addr = BASE_ADDR + ({8'd0, y_reg} * STRIDE) + {8'd0, x_reg};

  assign mem.mem_addr           = addr_reg;
  assign mem.mem_request        = req_reg;
  assign mem.mem_n_write_enable = 1'b1;
  assign mem.mem_data_read_size = 9'd1;

  assign pixel_valid = (level_reg != '0);
  assign pixel_data  = pixel_valid ? fifo_mem[rd_ptr_reg] : 16'h0000;
  assign underflow   = underflow_reg;
  assign fifo_level  = level_reg;
  assign pop         = pixel_req && pixel_valid;

  // Next-state, request and scan-position decode for the fetch sequencer.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    addr_next  = addr_reg;
    req_next   = req_reg;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        req_next = 1'b0;
        if (frame_start) begin
          x_next     = '0;
          y_next     = '0;
          flush      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (frame_start) begin
          x_next = '0;
          y_next = '0;
          flush  = 1'b1;
        end else if (level_reg != LEVEL_FULL && !mem.mem_busy) begin
          req_next   = 1'b1;
          addr_next  = fetch_addr;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (frame_start) begin
          // The in-flight word belongs to the old frame; wait it out in DRAIN.
          req_next   = 1'b0;
          flush      = 1'b1;
          state_next = DRAIN;
        end else if (mem.mem_data_ready) begin
          push     = 1'b1;
          req_next = 1'b0;
          if (x_reg == X_LAST) begin
            x_next     = '0;
            y_next     = y_reg + 16'd1;
            state_next = (y_reg == Y_LAST) ? DONE : ISSUE;
          end else begin
            x_next     = x_reg + 16'd1;
            state_next = ISSUE;
          end
        end
      end
      DRAIN: begin
        req_next = 1'b0;
        if (frame_start) flush = 1'b1;
        if (!mem.mem_busy) begin
          x_next     = '0;
          y_next     = '0;
          state_next = ISSUE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Sequencer state, scan position and the registered memory request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      addr_reg  <= '0;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      addr_reg  <= addr_next;
      req_reg   <= req_next;
    end
  end

  // Pixel storage; kept free of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem.mem_data_in;
  end

  // FIFO pointers, occupancy and sticky underflow; a flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      level_reg <= level_reg + LEVEL_ONE;
      else if (!push && pop) level_reg <= level_reg - LEVEL_ONE;
      if (pixel_req && !pixel_valid) underflow_reg <= 1'b1;
    end
  end
endmodule
